// File: rtl/hmmm_host_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hmmm_host_if_pkg
//  Description : Shared constants for the Hmmm host interface: the state
//                encoding seen on the state output, and the rotate amount
//                used by the optional load checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
package hmmm_host_if_pkg;

   // Host interface state encoding (visible on the 'state' output)
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   // Left-rotate applied to the running checksum before each XOR
   localparam int CSUM_ROT = 1;

   // State entered on an accepted load_start: a zero-length load has
   // nothing to stream, so the core is released immediately.
   function automatic logic [1:0] load_entry_state(input logic len_is_zero);
      return len_is_zero ? ST_RUN : ST_LOAD;
   endfunction

endpackage : hmmm_host_if_pkg
`default_nettype wire

// File: rtl/hmmm_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hmmm_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head entry is
//                presented on pop_data whenever the FIFO is non-empty; pop
//                simply advances to the next entry. Push into a full FIFO and
//                pop from an empty FIFO are ignored. flush empties the FIFO
//                and takes priority over push/pop in the same cycle.
//  Ports       : clk, rst (async, active-low)
//                flush            - discard all entries
//                push, push_data  - write request / data
//                pop              - advance head
//                pop_data         - current head (undefined when empty)
//                full, empty      - occupancy flags (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module hmmm_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;

   logic do_push;
   logic do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; contents are only observed while non-empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule : hmmm_fifo
`default_nettype wire

// File: rtl/hmmm_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : hmmm_host_if
//  Description : Host interface for the Hmmm core. Streams a program image
//                into RAM over a valid/ready channel with auto-incrementing
//                addresses while holding the core, then serves the core's
//                read/write instructions through an input FIFO (host->core)
//                and an output FIFO (core->host).
//  Ports       : clk, rst (async, active-low)
//                load_start/load_base/load_len - start a program load
//                s_valid/s_ready/s_data        - host -> block words
//                m_valid/m_ready/m_data        - block -> host words
//                ram_we/ram_addr/ram_wdata     - RAM write port (registered)
//                core_hold                     - core frozen
//                core_rd_req/core_rd_data      - core read instruction
//                core_wr_req/core_wr_data      - core write instruction
//                core_stall                    - core must repeat step
//                core_halt                     - core executed halt
//                state                         - IDLE/LOAD/RUN/HALTED
//                loaded_count                  - words written this load
//                checksum                      - load checksum (optional)
//  Config      : define HMMM_HOST_IF_CHECKSUM_EN to add the checksum output.
//  Revision    : 1.0 - initial release
// ============================================================================
module hmmm_host_if
   import hmmm_host_if_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W-1:0] load_len,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              core_hold,
   input  logic              core_rd_req,
   output logic [DATA_W-1:0] core_rd_data,
   input  logic              core_wr_req,
   input  logic [DATA_W-1:0] core_wr_data,
   output logic              core_stall,
   input  logic              core_halt,
   output logic [1:0]        state,
   output logic [ADDR_W-1:0] loaded_count
`ifdef HMMM_HOST_IF_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   logic [1:0]        next_state;
   logic [ADDR_W-1:0] load_addr;
   logic [ADDR_W-1:0] remaining;

   logic              start_ok;
   logic              load_hs;
   logic              in_run;

   logic              in_push, in_pop, in_full, in_empty;
   logic [DATA_W-1:0] in_head;
   logic              out_push, out_pop, out_full, out_empty;
   logic [DATA_W-1:0] out_head;

   assign in_run   = (state == ST_RUN);
   // load_start only counts while the core is idle or halted
   assign start_ok = load_start && ((state == ST_IDLE) || (state == ST_HALTED));
   // s_ready is constantly high in LOAD, so s_valid alone completes a transfer
   assign load_hs  = (state == ST_LOAD) && s_valid;

   // Core requests only act in RUN; full/empty are registered so a same-cycle
   // host push/pop never bypasses into the core's view.
   assign in_push  = in_run && s_valid && !in_full;
   assign in_pop   = in_run && core_rd_req && !in_empty;
   assign out_push = in_run && core_wr_req && !out_full;
   assign out_pop  = m_ready && !out_empty;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_HALTED: begin
            if (load_start) next_state = load_entry_state(load_len == '0);
         end
         ST_LOAD: begin
            if (load_hs && (remaining == ADDR_W'(1))) next_state = ST_RUN;
         end
         ST_RUN: begin
            if (core_halt) next_state = ST_HALTED;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      core_hold    = 1'b1;
      s_ready      = 1'b0;
      core_stall   = 1'b0;
      case (state)
         ST_LOAD: s_ready = 1'b1;
         ST_RUN: begin
            core_hold  = 1'b0;
            s_ready    = !in_full;
            core_stall = (core_rd_req && in_empty) || (core_wr_req && out_full);
         end
         default: ;
      endcase
      // The output FIFO drains to the host in every state
      m_valid      = !out_empty;
      m_data       = out_empty ? '0 : out_head;
      core_rd_data = in_empty ? '0 : in_head;
   end

   // ------------------------------------------------------------------------
   // Load datapath: RAM write port is registered one cycle behind the
   // handshake; address wraps modulo 2^ADDR_W.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         load_addr    <= '0;
         remaining    <= '0;
         loaded_count <= '0;
      end else begin
         ram_we <= load_hs;
         if (start_ok) begin
            load_addr    <= load_base;
            remaining    <= load_len;
            loaded_count <= '0;
         end else if (load_hs) begin
            ram_addr     <= load_addr;
            ram_wdata    <= s_data;
            load_addr    <= load_addr + 1'b1;
            remaining    <= remaining - 1'b1;
            loaded_count <= loaded_count + 1'b1;
         end
      end
   end

`ifdef HMMM_HOST_IF_CHECKSUM_EN
   // Running rotate-XOR over the loaded words; only updates on load
   // handshakes, so it is frozen once LOAD is left.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum <= '0;
      end else if (start_ok) begin
         checksum <= '0;
      end else if (load_hs) begin
         checksum <= ((checksum << CSUM_ROT) | (checksum >> (DATA_W - CSUM_ROT)))
                     ^ s_data;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // IO FIFOs. A new load discards stale host input but keeps core output
   // so the host can still collect it.
   // ------------------------------------------------------------------------
   hmmm_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_in_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (start_ok),
      .push      (in_push),
      .push_data (s_data),
      .pop       (in_pop),
      .pop_data  (in_head),
      .full      (in_full),
      .empty     (in_empty)
   );

   hmmm_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (out_push),
      .push_data (core_wr_data),
      .pop       (out_pop),
      .pop_data  (out_head),
      .full      (out_full),
      .empty     (out_empty)
   );

endmodule : hmmm_host_if
`default_nettype wire

// File: tb/tb_hmmm_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hmmm_host_if
//  Description : Self-checking bench for hmmm_host_if: table-driven load,
//                hand-written corner sequences, randomized RUN traffic
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hmmm_host_if;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic [AW-1:0] load_base, load_len;
   logic          s_valid, s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid, m_ready;
   logic [DW-1:0] m_data;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          core_hold;
   logic          core_rd_req, core_wr_req, core_stall, core_halt;
   logic [DW-1:0] core_rd_data, core_wr_data;
   logic [1:0]    state;
   logic [AW-1:0] loaded_count;
`ifdef HMMM_HOST_IF_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   hmmm_host_if #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .load_base    (load_base),
      .load_len     (load_len),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .core_hold    (core_hold),
      .core_rd_req  (core_rd_req),
      .core_rd_data (core_rd_data),
      .core_wr_req  (core_wr_req),
      .core_wr_data (core_wr_data),
      .core_stall   (core_stall),
      .core_halt    (core_halt),
      .state        (state),
      .loaded_count (loaded_count)
`ifdef HMMM_HOST_IF_CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int we_pulses = 0;
   logic [DW-1:0] expq[$];

   always @(negedge clk) if (ram_we) we_pulses++;

   typedef struct {
      logic [DW-1:0] data;      // word driven on s_data
      bit            gap;       // idle cycle before this word
      logic [AW-1:0] exp_addr;  // RAM address expected for this word
   } load_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [AW-1:0] base, input logic [AW-1:0] len);
      load_start = 1'b1; load_base = base; load_len = len;
      step();
      load_start = 1'b0;
   endtask

   // Collect n words from the output channel (m_ready held high), in order.
   task automatic drain(input int n);
      int got = 0;
      m_ready = 1'b1;
      for (int c = 0; c < 20 && got < n; c++) begin
         #1;
         if (m_valid && expq.size() > 0) begin
            check("drain_data", 32'(m_data), 32'(expq.pop_front()));
            got++;
         end
         step();
      end
      check("drain_count", got, n);
   endtask

   function automatic logic [DW-1:0] csum_next(input logic [DW-1:0] c, input logic [DW-1:0] w);
      return DW'((32'(c) * 2) % (1 << DW)) ^ DW'(32'(c) / (1 << (DW - 1))) ^ w;
   endfunction

   initial begin
      load_vec_t lv[4];
      int base_pulses;
      int inq_m[$];
      int outq_m[$];

      lv[0] = '{16'h00A1, 1'b0, 8'hFE};
      lv[1] = '{16'h00A2, 1'b0, 8'hFF};
      lv[2] = '{16'h00A3, 1'b1, 8'h00};
      lv[3] = '{16'h00A4, 1'b0, 8'h01};

      rst = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      core_rd_req = 1'b0; core_wr_req = 1'b0; core_wr_data = '0; core_halt = 1'b0;
      step(); step();

      // ---------------- reset state ----------------
      check("rst_state", 32'(state), 0);
      check("rst_ram_we", 32'(ram_we), 0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      check("rst_ram_wdata", 32'(ram_wdata), 0);
      check("rst_loaded_count", 32'(loaded_count), 0);
      check("rst_core_hold", 32'(core_hold), 1);
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_core_stall", 32'(core_stall), 0);
      check("rst_core_rd_data", 32'(core_rd_data), 0);
      rst = 1'b1;
      step();

      // ---------------- table-driven load with address wrap ----------------
      start_load(8'hFE, 8'd4);
      check("load_state", 32'(state), 1);
      check("load_hold", 32'(core_hold), 1);
      for (int i = 0; i < 4; i++) begin
         if (lv[i].gap) begin
            s_valid = 1'b0;
            step();
            check("gap_no_we", 32'(ram_we), 0);
         end
         s_valid = 1'b1; s_data = lv[i].data;
         #1;
         check("load_s_ready", 32'(s_ready), 1);
         step();
         s_valid = 1'b0;
         check("load_we", 32'(ram_we), 1);
         check("load_addr", 32'(ram_addr), 32'(lv[i].exp_addr));
         check("load_wdata", 32'(ram_wdata), 32'(lv[i].data));
         check("load_count", 32'(loaded_count), i + 1);
      end
      check("load_done_state", 32'(state), 2);
      check("load_done_hold", 32'(core_hold), 0);
      step();
      check("load_done_we_low", 32'(ram_we), 0);

      // ---------------- reset mid-load ----------------
      rst = 1'b0; step(); rst = 1'b1; step();
      base_pulses = we_pulses;
      start_load(8'h10, 8'd5);
      s_valid = 1'b1; s_data = 16'h0B01; step();
      s_valid = 1'b0; step();
      s_valid = 1'b1; s_data = 16'h0B02; step();
      @(negedge clk);
      #1;
      rst = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step(); step();
      s_valid = 1'b0;
      check("abort_we_pulses", we_pulses - base_pulses, 2);
      check("abort_state", 32'(state), 0);
      check("abort_hold", 32'(core_hold), 1);
      check("abort_s_ready", 32'(s_ready), 0);

      // ---------------- zero-length load, read stall ----------------
      start_load(8'h00, 8'd0);
      check("len0_state", 32'(state), 2);
      check("len0_hold", 32'(core_hold), 0);
      core_rd_req = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
      #1;
      check("rd_empty_stall", 32'(core_stall), 1);
      check("rd_push_ready", 32'(s_ready), 1);
      step();
      s_valid = 1'b0;
      #1;
      check("rd_data", 32'(core_rd_data), 16'h1234);
      check("rd_no_stall", 32'(core_stall), 0);
      step();
      check("rd_empty_after", 32'(core_stall), 1);
      core_rd_req = 1'b0;

      // ---------------- output FIFO full stall ----------------
      m_ready = 1'b0; core_wr_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         core_wr_data = DW'(16'h0100 + i);
         expq.push_back(DW'(16'h0100 + i));
         #1;
         check("wr_stall", 32'(core_stall), (i == 4) ? 1 : 0);
         if (i < 4) step();
      end
      m_ready = 1'b1;
      #1;
      check("wr_full_stall_hold", 32'(core_stall), 1);
      check("wr_head", 32'(m_data), 32'(expq.pop_front()));
      step();
      check("wr_stall_clear", 32'(core_stall), 0);
      check("wr_head2", 32'(m_data), 32'(expq.pop_front()));
      step();
      core_wr_req = 1'b0;
      drain(3);
      check("wr_drained", 32'(m_valid), 0);

      // ---------------- halt with pending output ----------------
      m_ready = 1'b0; core_wr_req = 1'b1;
      core_wr_data = 16'h0200; expq.push_back(16'h0200); step();
      core_wr_data = 16'h0201; expq.push_back(16'h0201); step();
      core_wr_req = 1'b0; core_halt = 1'b1;
      step();
      core_halt = 1'b0;
      check("halt_state", 32'(state), 3);
      check("halt_hold", 32'(core_hold), 1);
      check("halt_s_ready", 32'(s_ready), 0);
      core_rd_req = 1'b1; core_wr_req = 1'b1; core_wr_data = 16'hDEAD;
      #1;
      check("halt_no_stall", 32'(core_stall), 0);
      step();
      core_rd_req = 1'b0; core_wr_req = 1'b0;
      drain(2);
      check("halt_drained", 32'(m_valid), 0);
      start_load(8'h00, 8'd0);
      check("relaunch_state", 32'(state), 2);

      // ---------------- randomized RUN traffic vs queue model ----------------
      for (int cyc = 0; cyc < 400; cyc++) begin
         int rd_ok, wr_ok, hp_ok, hpop_ok;
         s_valid      = 1'($urandom_range(0, 1));
         s_data       = DW'($urandom);
         m_ready      = 1'($urandom_range(0, 2) != 0);
         core_rd_req  = 1'($urandom_range(0, 1));
         core_wr_req  = 1'($urandom_range(0, 1));
         core_wr_data = DW'($urandom);
         #1;
         check("rnd_s_ready", 32'(s_ready), (inq_m.size() < DEPTH) ? 1 : 0);
         check("rnd_stall", 32'(core_stall),
               ((core_rd_req && inq_m.size() == 0) ||
                (core_wr_req && outq_m.size() == DEPTH)) ? 1 : 0);
         check("rnd_m_valid", 32'(m_valid), (outq_m.size() != 0) ? 1 : 0);
         if (outq_m.size() != 0) check("rnd_m_data", 32'(m_data), outq_m[0]);
         if (inq_m.size() != 0)  check("rnd_rd_data", 32'(core_rd_data), inq_m[0]);
         // Decisions use occupancy before the clock edge
         rd_ok   = core_rd_req && inq_m.size() > 0;
         hp_ok   = s_valid && inq_m.size() < DEPTH;
         hpop_ok = m_ready && outq_m.size() > 0;
         wr_ok   = core_wr_req && outq_m.size() < DEPTH;
         if (rd_ok)   void'(inq_m.pop_front());
         if (hp_ok)   inq_m.push_back(int'(s_data));
         if (hpop_ok) void'(outq_m.pop_front());
         if (wr_ok)   outq_m.push_back(int'(core_wr_data));
         step();
      end
      s_valid = 1'b0; core_rd_req = 1'b0; core_wr_req = 1'b0; m_ready = 1'b0;

`ifdef HMMM_HOST_IF_CHECKSUM_EN
      // ---------------- checksum ----------------
      begin
         logic [DW-1:0] words[3][2];
         int            lens[3];
         logic [DW-1:0] model;
         words[0][0] = 16'h0001; words[0][1] = 16'h0002; lens[0] = 2;
         words[1][0] = 16'h8000; words[1][1] = 16'h0001; lens[1] = 2;
         words[2][0] = 16'h00FF; words[2][1] = 16'h0000; lens[2] = 1;
         for (int t = 0; t < 3; t++) begin
            core_halt = 1'b1; step(); core_halt = 1'b0;
            start_load(8'h40, AW'(lens[t]));
            model = '0;
            for (int k = 0; k < lens[t]; k++) begin
               s_valid = 1'b1; s_data = words[t][k];
               model = csum_next(model, words[t][k]);
               step();
            end
            s_valid = 1'b1; s_data = 16'h5555;
            step();
            s_valid = 1'b0;
            check("csum_value", 32'(checksum), 32'(model));
         end
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_hmmm_host_if
`default_nettype wire

// File: doc/hmmm_host_if.md
Name: hmmm_host_if

Overview:
Parametrised host interface for the Hmmm core; successor to the raw pgrm_addr/pgrm_data/read/write pins. It streams a program image into RAM over a valid/ready channel with auto-incrementing addresses, holds the core during load, then serves the core's read/write instructions through buffered input and output FIFOs. It sits between the external host and the core's RAM write port and IO instruction handshake.

Parameters:
DATA_W, 16, bus/word width
ADDR_W, 8, RAM address width
FIFO_DEPTH, 4, entries per IO FIFO (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
load_start  in  1  pulse: begin program load (IDLE/HALTED only)
load_base  in  ADDR_W  first RAM address, sampled on load_start
load_len  in  ADDR_W  word count, sampled on load_start
s_valid  in  1  host→block word valid
s_ready  out  1  block accepts host word
s_data  in  DATA_W  host word
m_valid  out  1  block→host output word valid
m_ready  in  1  host accepts output word
m_data  out  DATA_W  output word
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
core_hold  out  1  core frozen (clock gate/reset hold)
core_rd_req  in  1  core executing read
core_rd_data  out  DATA_W  word returned to core
core_wr_req  in  1  core executing write
core_wr_data  in  DATA_W  word from core
core_stall  out  1  core must repeat current step
core_halt  in  1  core executed halt
state  out  2  IDLE=0 LOAD=1 RUN=2 HALTED=3
loaded_count  out  ADDR_W  words written this load

Behaviour:
- Reset: state=IDLE, FIFOs empty, ram_we=0, ram_addr=0, ram_wdata=0, loaded_count=0, core_hold=1, s_ready=0, m_valid=0, core_stall=0, core_rd_data=0. Reset mid-load abandons load; no further RAM writes.
- IDLE: core_hold=1, s_ready=0. load_start → LOAD (load_len=0 → RUN directly); latch load_base as address, load_len as remaining.
- LOAD: core_hold=1, s_ready=1. Each s_valid&&s_ready: next cycle ram_we=1, ram_addr=current address, ram_wdata=s_data (1-cycle registered latency); address+1 mod 2^ADDR_W (wraps, no error); loaded_count+1; remaining−1. Handshake of final word → RUN next cycle; s_ready=0 from that cycle; final ram_we still issues. load_start ignored.
- RUN: core_hold=0. Host words go to input FIFO: s_ready=!in_full. Output FIFO drives m_valid=!out_empty, m_data=head; pop on m_valid&&m_ready.
- core_rd_req: in FIFO non-empty → core_rd_data=head (first-word-fall-through), pop same cycle, stall=0; empty → core_stall=1, no pop. Host push into empty FIFO same cycle does not bypass; data visible next cycle.
- core_wr_req: out FIFO not full → push core_wr_data; full → core_stall=1. Host pop of full FIFO same cycle does not free the slot this cycle.
- core_stall = (rd_req&&in_empty) || (wr_req&&out_full); rd and wr evaluated independently.
- core_halt in RUN → HALTED. HALTED: core_hold=1, s_ready=0, output FIFO keeps draining to host; core requests ignored, stall=0. load_start → LOAD, input FIFO flushed, output FIFO retained.
- Outside RUN, core_rd_req/core_wr_req ignored.

Optional Feature:
HMMM_HOST_IF_CHECKSUM_EN: adds output checksum[DATA_W]; cleared on load_start; each loaded word: checksum = (checksum rotl 1) XOR word; frozen on leaving LOAD. Without macro: port and logic absent.

Decomposition:
- Package hmmm_host_if_pkg: state encoding constants (IDLE/LOAD/RUN/HALTED), checksum rotate amount.
- Sub-module hmmm_fifo (DATA_W, DEPTH): sync FWFT FIFO, push/pop/full/empty/flush; instanced twice.

Test Plan:
- Reset, load_start base=0xFE len=4, words A1..A4 → ram writes at FE,FF,00,01 one cycle after each handshake; state RUN after 4th; loaded_count=4.
- Load with s_valid gaps and rst low after 2nd word → only 2 ram_we pulses; state IDLE; core_hold=1.
- RUN: core_rd_req with input FIFO empty → core_stall=1; host pushes 0x1234 → next cycle core_rd_data=0x1234, stall=0, FIFO empty after.
- RUN: m_ready=0, 5 core writes, DEPTH=4 → 5th stalls; m_ready=1 → words drain in order, stall clears next cycle.
- core_halt with 2 words in output FIFO → HALTED, core_hold=1, both words still delivered; load_start len=0 → RUN immediately.
- With CHECKSUM_EN: load 0x0001,0x0002 → checksum=0x0000; load 0x8000,0x0001 → checksum=0x0000; load 0x00FF → 0x00FF.
